// File: rtl/judge_hp_unit.sv
// Answer judge and HP tracker: iterative restoring-remainder factor check, local/opponent arbitration, HP counters.
// Optional feature: define DRAW_DAMAGE_EN to make a DRAW cost both players one HP.
module judge_hp_unit #(
  parameter int W       = 8,
  parameter int HPW     = 2,
  parameter int HP_INIT = 3
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [3:0]     STATE,
  input  logic [W-1:0]   QUE_NUM,
  input  logic [W-1:0]   FACT,
  input  logic           DEC,
  input  logic           OPP_OK,
  output logic [1:0]     JUDG_OUT,
  output logic [1:0]     WRONG_OUT,
  output logic [1:0]     HP_OUT,
  output logic [HPW-1:0] HP_LOCAL,
  output logic [HPW-1:0] HP_OPP,
  output logic           BUSY
);

  localparam logic [3:0] ST_READY    = 4'd2;
  localparam logic [3:0] ST_QUESTION = 4'd3;
  localparam logic [3:0] ST_INPUT    = 4'd4;
  localparam logic [3:0] ST_DRAW     = 4'd6;
  localparam logic [3:0] ST_WRONG    = 4'd7;
  localparam logic [3:0] ST_GOOD     = 4'd8;
  localparam logic [3:0] ST_OUCH     = 4'd9;
  localparam logic [3:0] ST_WIN      = 4'd10;
  localparam logic [3:0] ST_LOSE     = 4'd11;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, VERDICT = 2'd2} fsm_t;

  fsm_t           fsm_r, fsm_nxt_s;
  logic [W-1:0]   dvd_r, div_r, rem_r, rem_nxt_s, sub_s;
  logic [W:0]     rem_sh_s;
  logic [CW-1:0]  cnt_r;
  logic           bad_r, opp_flag_r, opp_chk_r;
  logic [1:0]     judg_r, wrong_r;
  logic [3:0]     prev_state_r;
  logic [HPW-1:0] hp_local_r, hp_opp_r;
  logic           in_input_s, clear_s, accept_s, range_bad_s, last_s, opp_valid_s;
  logic           entry_s, new_game_s;

  function automatic logic [HPW-1:0] dec_sat(input logic [HPW-1:0] v);
    dec_sat = (v == {HPW{1'b0}}) ? v : v - HPW'(1);
  endfunction

  assign in_input_s  = (STATE == ST_INPUT);
  // Leaving INPUT while the engine is busy counts as a round clear.
  assign clear_s     = (STATE == ST_READY) || ((fsm_r != IDLE) && !in_input_s);
  assign accept_s    = (fsm_r == IDLE) && in_input_s && DEC && (wrong_r == 2'b00);
  assign range_bad_s = (FACT < W'(2)) || (FACT >= QUE_NUM);
  assign last_s      = (cnt_r == CW'(W - 1));
  assign opp_valid_s = OPP_OK && ((STATE == ST_QUESTION) || in_input_s);
  assign entry_s     = (STATE != prev_state_r);
  assign new_game_s  = (STATE == ST_READY) && ((prev_state_r == ST_WIN) || (prev_state_r == ST_LOSE));

  // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
  assign rem_sh_s  = {rem_r, dvd_r[W-1]};
  assign sub_s     = rem_sh_s[W-1:0] - div_r;
  assign rem_nxt_s = (rem_sh_s >= {1'b0, div_r}) ? sub_s : rem_sh_s[W-1:0];

  // Engine state register.
  always_ff @(posedge CLK) begin
    if (!RST) fsm_r <= IDLE;
    else      fsm_r <= fsm_nxt_s;
  end

  // Engine next-state logic.
  always_comb begin
    fsm_nxt_s = fsm_r;
    case (fsm_r)
      IDLE: begin
        if (accept_s) fsm_nxt_s = range_bad_s ? VERDICT : CHECK;
        else          fsm_nxt_s = IDLE;
      end
      CHECK: begin
        if (clear_s)     fsm_nxt_s = IDLE;
        else if (last_s) fsm_nxt_s = VERDICT;
        else             fsm_nxt_s = CHECK;
      end
      VERDICT: fsm_nxt_s = IDLE;
      default: fsm_nxt_s = IDLE;
    endcase
  end

  // Remainder datapath: operands latched on accept, one bit per CHECK cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      dvd_r <= '0;
      div_r <= '0;
      rem_r <= '0;
      cnt_r <= '0;
      bad_r <= 1'b0;
    end else if (accept_s) begin
      dvd_r <= QUE_NUM;
      div_r <= FACT;
      rem_r <= '0;
      cnt_r <= '0;
      bad_r <= range_bad_s;
    end else if (fsm_r == CHECK) begin
      dvd_r <= {dvd_r[W-2:0], 1'b0};
      rem_r <= rem_nxt_s;
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Verdict, arbitration and opponent flags.
  always_ff @(posedge CLK) begin
    if (!RST || clear_s) begin
      judg_r     <= 2'b00;
      wrong_r    <= 2'b00;
      opp_flag_r <= 1'b0;
      opp_chk_r  <= 1'b0;
    end else if (fsm_r == VERDICT) begin
      if (bad_r || (rem_r != '0)) begin
        wrong_r <= 2'b11;
      end else begin
        wrong_r <= 2'b01;
        if (judg_r == 2'b10)                 judg_r <= 2'b10;
        else if (opp_chk_r || opp_valid_s)   judg_r <= 2'b11;
        else if (opp_flag_r)                 judg_r <= 2'b10;
        else                                 judg_r <= 2'b01;
      end
      if (opp_valid_s) opp_flag_r <= 1'b1;
    end else if (fsm_r == CHECK) begin
      if (opp_valid_s) begin
        opp_flag_r <= 1'b1;
        opp_chk_r  <= 1'b1;
      end
    end else begin
      if (accept_s) opp_chk_r <= 1'b0;
      // A held local-correct verdict makes a late opponent strobe irrelevant.
      if (opp_valid_s && (wrong_r != 2'b01)) begin
        opp_flag_r <= 1'b1;
        judg_r     <= 2'b10;
      end
      if ((STATE == ST_WRONG) && (wrong_r == 2'b11)) wrong_r <= 2'b00;
    end
  end

  // HP counters, updated on entry into GOOD/OUCH (and DRAW when enabled).
  always_ff @(posedge CLK) begin
    if (!RST) begin
      prev_state_r <= 4'd0;
      hp_local_r   <= HPW'(HP_INIT);
      hp_opp_r     <= HPW'(HP_INIT);
    end else begin
      prev_state_r <= STATE;
      if (new_game_s) begin
        hp_local_r <= HPW'(HP_INIT);
        hp_opp_r   <= HPW'(HP_INIT);
      end else if (entry_s) begin
        case (STATE)
          ST_GOOD: hp_opp_r   <= dec_sat(hp_opp_r);
          ST_OUCH: hp_local_r <= dec_sat(hp_local_r);
`ifdef DRAW_DAMAGE_EN
          ST_DRAW: begin
            hp_local_r <= dec_sat(hp_local_r);
            hp_opp_r   <= dec_sat(hp_opp_r);
          end
`else
          ST_DRAW: hp_local_r <= hp_local_r;
`endif
          default: hp_local_r <= hp_local_r;
        endcase
      end
    end
  end

  assign JUDG_OUT  = judg_r;
  assign WRONG_OUT = wrong_r;
  assign BUSY      = (fsm_r == CHECK);
  assign HP_LOCAL  = hp_local_r;
  assign HP_OPP    = hp_opp_r;
  assign HP_OUT    = {(hp_opp_r == {HPW{1'b0}}), (hp_local_r == {HPW{1'b0}})};

endmodule

// File: tb/tb_judge_hp_unit.sv
// Directed bench for judge_hp_unit: vector table for check rounds, hand sequences for HP and abort cases.
module tb_judge_hp_unit;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] STATE = 4'd0;
  logic [7:0] QUE_NUM = 8'd0;
  logic [7:0] FACT = 8'd0;
  logic       DEC = 1'b0;
  logic       OPP_OK = 1'b0;
  logic [1:0] JUDG_OUT, WRONG_OUT, HP_OUT, HP_LOCAL, HP_OPP;
  logic       BUSY;

  int n_cmp = 0;
  int n_fail = 0;

  judge_hp_unit #(.W(8), .HPW(2), .HP_INIT(3)) dut (
    .CLK(CLK), .RST(RST), .STATE(STATE), .QUE_NUM(QUE_NUM), .FACT(FACT),
    .DEC(DEC), .OPP_OK(OPP_OK), .JUDG_OUT(JUDG_OUT), .WRONG_OUT(WRONG_OUT),
    .HP_OUT(HP_OUT), .HP_LOCAL(HP_LOCAL), .HP_OPP(HP_OPP), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] fact;
    logic [7:0] que;
    int         opp_at;
    int         busy;
    int         lat;
    logic [1:0] judg;
    logic [1:0] wrong;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic round_clear();
    STATE = 4'd2;
    tick();
    STATE = 4'd4;
    tick();
  endtask

  // Pulse DEC and wait (bounded) for a verdict; opp_at gives the cycle to pulse OPP_OK.
  task automatic run_dec(input logic [7:0] f, input logic [7:0] q, input int opp_at,
                         output int busy_n, output int lat, output logic [1:0] j, output logic [1:0] w);
    FACT = f;
    QUE_NUM = q;
    DEC = 1'b1;
    tick();
    DEC = 1'b0;
    lat = 0;
    busy_n = 0;
    while (WRONG_OUT == 2'b00 && lat < 20) begin
      if (BUSY) busy_n++;
      OPP_OK = (lat == opp_at);
      tick();
      OPP_OK = 1'b0;
      lat++;
    end
    j = JUDG_OUT;
    w = WRONG_OUT;
  endtask

  initial begin
    int bn, ln;
    logic [1:0] jv, wv;

    vecs[0]  = '{8'd7,   8'd91,  -1, 8, 9, 2'b01, 2'b01};
    vecs[1]  = '{8'd6,   8'd91,  -1, 8, 9, 2'b00, 2'b11};
    vecs[2]  = '{8'd13,  8'd91,  -1, 8, 9, 2'b01, 2'b01};
    vecs[3]  = '{8'd1,   8'd91,  -1, 0, 1, 2'b00, 2'b11};
    vecs[4]  = '{8'd91,  8'd91,  -1, 0, 1, 2'b00, 2'b11};
    vecs[5]  = '{8'd0,   8'd91,  -1, 0, 1, 2'b00, 2'b11};
    vecs[6]  = '{8'd5,   8'd255, -1, 8, 9, 2'b01, 2'b01};
    vecs[7]  = '{8'd17,  8'd255, -1, 8, 9, 2'b01, 2'b01};
    vecs[8]  = '{8'd127, 8'd254, -1, 8, 9, 2'b01, 2'b01};
    vecs[9]  = '{8'd128, 8'd255, -1, 8, 9, 2'b00, 2'b11};
    vecs[10] = '{8'd16,  8'd128, -1, 8, 9, 2'b01, 2'b01};
    vecs[11] = '{8'd2,   8'd2,   -1, 0, 1, 2'b00, 2'b11};
    vecs[12] = '{8'd7,   8'd91,   3, 8, 9, 2'b11, 2'b01};
    vecs[13] = '{8'd13,  8'd91,   8, 8, 9, 2'b11, 2'b01};
    vecs[14] = '{8'd6,   8'd91,   3, 8, 9, 2'b00, 2'b11};
    vecs[15] = '{8'd2,   8'd3,   -1, 8, 9, 2'b00, 2'b11};

    // Reset state
    RST = 1'b0;
    tick();
    tick();
    chk("rst_judg", JUDG_OUT, 0);
    chk("rst_wrong", WRONG_OUT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_hp_local", HP_LOCAL, 3);
    chk("rst_hp_opp", HP_OPP, 3);
    chk("rst_hp_out", HP_OUT, 0);
    RST = 1'b1;

    // Table of check rounds
    for (int i = 0; i < 16; i++) begin
      round_clear();
      run_dec(vecs[i].fact, vecs[i].que, vecs[i].opp_at, bn, ln, jv, wv);
      chk($sformatf("v%0d_busy", i), bn, vecs[i].busy);
      chk($sformatf("v%0d_lat", i), ln, vecs[i].lat);
      chk($sformatf("v%0d_judg", i), jv, vecs[i].judg);
      chk($sformatf("v%0d_wrong", i), wv, vecs[i].wrong);
    end

    // Wrong answer, DEC ignored while held, WRONG state re-arms
    round_clear();
    run_dec(8'd6, 8'd91, -1, bn, ln, jv, wv);
    chk("rearm_first_wrong", wv, 3);
    FACT = 8'd7;
    DEC = 1'b1;
    tick();
    DEC = 1'b0;
    chk("held_dec_busy", BUSY, 0);
    tick();
    chk("held_dec_wrong", WRONG_OUT, 3);
    STATE = 4'd7;
    tick();
    chk("wrong_state_clear", WRONG_OUT, 0);
    STATE = 4'd4;
    tick();
    run_dec(8'd13, 8'd91, -1, bn, ln, jv, wv);
    chk("rearm_judg", jv, 1);
    chk("rearm_wrong", wv, 1);

    // Opponent first while idle
    round_clear();
    OPP_OK = 1'b1;
    tick();
    OPP_OK = 1'b0;
    chk("opp_idle_judg", JUDG_OUT, 2);
    chk("opp_idle_wrong", WRONG_OUT, 0);
    run_dec(8'd7, 8'd91, -1, bn, ln, jv, wv);
    chk("opp_then_local_judg", jv, 2);
    chk("opp_then_local_wrong", wv, 1);

    // Late opponent after local-correct held is ignored
    round_clear();
    run_dec(8'd7, 8'd91, -1, bn, ln, jv, wv);
    OPP_OK = 1'b1;
    tick();
    OPP_OK = 1'b0;
    tick();
    chk("late_opp_judg", JUDG_OUT, 1);

    // DRAW entry
    STATE = 4'd6;
    tick();
    tick();
`ifdef DRAW_DAMAGE_EN
    chk("draw_hp_local", HP_LOCAL, 2);
    chk("draw_hp_opp", HP_OPP, 2);
`else
    chk("draw_hp_local", HP_LOCAL, 3);
    chk("draw_hp_opp", HP_OPP, 3);
`endif

    // GOOD entries, saturation, OUCH, new game
    RST = 1'b0;
    tick();
    RST = 1'b1;
    for (int k = 0; k < 4; k++) begin
      STATE = 4'd8;
      tick();
      tick();
      chk($sformatf("good%0d_hp_opp", k), HP_OPP, (k < 3) ? 2 - k : 0);
      STATE = 4'd4;
      tick();
    end
    chk("good_hp_out", HP_OUT, 2);
    STATE = 4'd9;
    tick();
    chk("ouch_hp_local", HP_LOCAL, 2);
    STATE = 4'd10;
    tick();
    STATE = 4'd2;
    tick();
    chk("newgame_hp_local", HP_LOCAL, 3);
    chk("newgame_hp_opp", HP_OPP, 3);
    chk("newgame_hp_out", HP_OUT, 0);

    // Reset mid-check
    round_clear();
    FACT = 8'd7;
    QUE_NUM = 8'd91;
    DEC = 1'b1;
    tick();
    DEC = 1'b0;
    tick();
    tick();
    chk("midrst_busy_before", BUSY, 1);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    chk("midrst_busy", BUSY, 0);
    chk("midrst_wrong", WRONG_OUT, 0);
    for (int k = 0; k < 10; k++) tick();
    chk("midrst_no_verdict", WRONG_OUT, 0);

    // READY aborts check in progress
    round_clear();
    DEC = 1'b1;
    tick();
    DEC = 1'b0;
    tick();
    STATE = 4'd2;
    tick();
    chk("abort_busy", BUSY, 0);
    STATE = 4'd4;
    for (int k = 0; k < 10; k++) tick();
    chk("abort_no_verdict", WRONG_OUT, 0);
    chk("abort_judg", JUDG_OUT, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
